// File: rtl/fir_decimator_if.sv
// Sample-stream handshake bundle for the decimating FIR: high-rate input side
// and decimated, registered output side.
interface fir_decimator_if #(
  parameter int INPUT_WORD_SIZE  = 16,
  parameter int OUTPUT_WORD_SIZE = 35
);
  logic [INPUT_WORD_SIZE-1:0]  data_in;
  logic                        valid_in;
  logic                        src_ready_out;
  logic [OUTPUT_WORD_SIZE-1:0] data_out;
  logic                        valid_out;
  logic                        dst_ready_in;

  modport master (
    output data_in, valid_in, dst_ready_in,
    input  src_ready_out, data_out, valid_out
  );

  modport slave (
    input  data_in, valid_in, dst_ready_in,
    output src_ready_out, data_out, valid_out
  );
endinterface

// File: rtl/fir_decimator.sv
// Decimating FIR: full-rate convolution over the live sample plus delay line,
// one registered output captured on every DECIM_FACTOR-th accepted input.
module fir_decimator_tap #(
  parameter int IW = 16,
  parameter int CW = 16
) (
  input  logic [IW-1:0]    i_sample,
  input  logic [CW-1:0]    i_coeff,
  output logic [IW+CW-1:0] o_prod
);
  logic signed [IW+CW-1:0] w_a;
  logic signed [IW+CW-1:0] w_b;

  assign w_a    = $signed({{CW{i_sample[IW-1]}}, i_sample});
  assign w_b    = $signed({{IW{i_coeff[CW-1]}}, i_coeff});
  assign o_prod = w_a * w_b;
endmodule

module fir_decimator #(
  parameter int INPUT_WORD_SIZE = 16,
  parameter int COEFF_WORD_SIZE = 16,
  parameter int N_COEFFS        = 8,
  parameter int DECIM_FACTOR    = 4
) (
  input  logic                                clk,
  input  logic                                arst_n,
  input  logic                                bypass,
  input  logic [N_COEFFS*COEFF_WORD_SIZE-1:0] coeff,
  fir_decimator_if.slave                      bus
);
  localparam int IW  = INPUT_WORD_SIZE;
  localparam int CW  = COEFF_WORD_SIZE;
  localparam int PW  = IW + CW;
  localparam int OW  = INPUT_WORD_SIZE + COEFF_WORD_SIZE + $clog2(N_COEFFS);
  localparam int PHW = $clog2(DECIM_FACTOR);
  localparam logic [PHW-1:0] LAST_PHASE = PHW'(DECIM_FACTOR - 1);

  logic [N_COEFFS-2:0][IW-1:0] r_taps;
  logic [PHW-1:0]              r_phase;
  logic [OW-1:0]               r_data;
  logic                        r_valid;

  logic [N_COEFFS-1:0][IW-1:0] w_samples;
  logic [N_COEFFS-1:0][PW-1:0] w_prod;
  logic signed [OW-1:0]        w_acc;
  logic signed [OW-1:0]        w_bp;
  logic                        w_ready;
  logic                        w_accept;
  logic                        w_capture;

  assign w_ready   = ~r_valid | bus.dst_ready_in;
  assign w_accept  = bus.valid_in & w_ready;
  assign w_capture = w_accept & (r_phase == LAST_PHASE);

  // Tap 0 multiplies the live input so the output lands one clock after the M-th sample.
  assign w_samples[0] = bus.data_in;
  for (genvar k = 1; k < N_COEFFS; k++) begin : g_smp
    assign w_samples[k] = r_taps[k-1];
  end

  for (genvar k = 0; k < N_COEFFS; k++) begin : g_tap
    fir_decimator_tap #(.IW(IW), .CW(CW)) u_tap (
      .i_sample (w_samples[k]),
      .i_coeff  (coeff[k*CW +: CW]),
      .o_prod   (w_prod[k])
    );
  end

  always_comb begin
    w_acc = '0;
    for (int k = 0; k < N_COEFFS; k++)
      w_acc = w_acc + OW'($signed(w_prod[k]));
  end

  // Bypass is the input scaled by a unity Q1.(CW-1) coefficient.
  assign w_bp = $signed({{(OW-IW){bus.data_in[IW-1]}}, bus.data_in}) <<< (CW - 1);

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_taps  <= '0;
      r_phase <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
    end else begin
      if (w_accept) begin
        for (int i = N_COEFFS - 2; i > 0; i--)
          r_taps[i] <= r_taps[i-1];
        r_taps[0] <= bus.data_in;
        r_phase   <= (r_phase == LAST_PHASE) ? '0 : r_phase + PHW'(1);
      end
      // A capture takes priority over a drain so one output per cycle is sustainable.
      if (w_capture) begin
        r_data  <= bypass ? w_bp : w_acc;
        r_valid <= 1'b1;
      end else if (r_valid & bus.dst_ready_in) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign bus.src_ready_out = w_ready;
  assign bus.data_out      = r_data;
  assign bus.valid_out     = r_valid;
endmodule

// File: tb/tb_fir_decimator.sv
// Randomized and directed bench for fir_decimator against a sample-history model.
module tb_fir_decimator;
  localparam int IW = 16, CW = 16, N = 8, M = 4;
  localparam int OW = IW + CW + $clog2(N);

  logic          clk = 1'b0;
  logic          arst_n = 1'b0;
  logic          bypass = 1'b0;
  logic [N*CW-1:0] coeff = '0;

  fir_decimator_if #(.INPUT_WORD_SIZE(IW), .OUTPUT_WORD_SIZE(OW)) bus ();

  fir_decimator #(
    .INPUT_WORD_SIZE(IW), .COEFF_WORD_SIZE(CW), .N_COEFFS(N), .DECIM_FACTOR(M)
  ) dut (
    .clk    (clk),
    .arst_n (arst_n),
    .bypass (bypass),
    .coeff  (coeff),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Model: every sample accepted since reset, plus output bookkeeping.
  int               mc[N];
  longint           hist[$];
  int               m_cnt;
  bit               m_valid;
  bit               m_rdy;
  logic             obs_rdy;
  logic [OW-1:0]    exp_q[$];
  logic [OW-1:0]    got_q[$];

  task automatic set_coeffs(input int c[N]);
    for (int k = 0; k < N; k++) begin
      mc[k] = c[k];
      coeff[k*CW +: CW] = CW'(c[k]);
    end
  endtask

  task automatic model_clear();
    hist.delete(); exp_q.delete(); got_q.delete();
    m_cnt = 0; m_valid = 0;
  endtask

  task automatic do_reset();
    arst_n = 1'b0;
    bus.valid_in = 1'b0; bus.data_in = '0; bus.dst_ready_in = 1'b1; bypass = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk) arst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // One clock: drive, observe consumption, advance model, step past the edge.
  task automatic tick(input bit v, input logic [IW-1:0] d, input bit rdy, input bit byp);
    bit acc, cap;
    longint y;
    bus.valid_in = v; bus.data_in = d; bus.dst_ready_in = rdy; bypass = byp;
    #1;
    obs_rdy = bus.src_ready_out;
    m_rdy = !m_valid || rdy;
    if (bus.valid_out && rdy) got_q.push_back(bus.data_out);
    acc = v && m_rdy;
    cap = acc && (m_cnt % M == M - 1);
    if (cap) begin
      if (byp) y = longint'($signed(d)) * (longint'(1) << (CW - 1));
      else begin
        y = longint'($signed(d)) * mc[0];
        for (int k = 1; k < N; k++)
          if (hist.size() >= k) y += hist[hist.size()-k] * mc[k];
      end
      exp_q.push_back(OW'(y));
      m_valid = 1;
    end else if (m_valid && rdy) m_valid = 0;
    if (acc) begin hist.push_back(longint'($signed(d))); m_cnt++; end
    @(posedge clk); #1;
  endtask

  int ramp[N] = '{1, 2, 3, 4, 5, 6, 7, 8};
  int ones[N] = '{1, 1, 1, 1, 1, 1, 1, 1};

  task automatic test_reset();
    arst_n = 1'b0; bus.valid_in = 1'b1; bus.data_in = 16'd7; bus.dst_ready_in = 1'b1;
    model_clear();
    set_coeffs(ramp);
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.valid_out !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", bus.valid_out); end
    checks++; if (bus.data_out !== '0) begin failures++; $display("FAIL reset_data got=%0d exp=0", bus.data_out); end
    checks++; if (bus.src_ready_out !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", bus.src_ready_out); end
    @(negedge clk) arst_n = 1'b1; bus.valid_in = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      tick(1, 16'd1, 1, 0);
      checks++;
      if (bus.valid_out !== (i == 3)) begin failures++; $display("FAIL reset_first_out[%0d] valid got=%b exp=%b", i, bus.valid_out, i == 3); end
    end
    checks++; if (bus.data_out !== OW'(10)) begin failures++; $display("FAIL reset_first_data got=%0d exp=10", $signed(bus.data_out)); end
  endtask

  task automatic test_impulse();
    int imp[4] = '{4, 8, 0, 0};
    do_reset();
    set_coeffs(ramp);
    for (int i = 0; i < 16; i++) begin
      tick(1, (i == 0) ? 16'd1 : 16'd0, 1, 0);
      checks++;
      if (bus.valid_out !== (i % 4 == 3)) begin failures++; $display("FAIL impulse_valid[%0d] got=%b exp=%b", i, bus.valid_out, i % 4 == 3); end
      if (i % 4 == 3) begin
        checks++;
        if (bus.data_out !== OW'(imp[i/4])) begin failures++; $display("FAIL impulse_data[%0d] got=%0d exp=%0d", i, $signed(bus.data_out), imp[i/4]); end
      end
    end
  endtask

  task automatic test_dc_gaps();
    int dc[3] = '{400, 800, 800};
    do_reset();
    set_coeffs(ones);
    for (int i = 0; i < 24; i++) begin
      tick(i % 2 == 0, 16'd100, 1, 0);
      checks++;
      if (bus.valid_out !== (i % 8 == 6)) begin failures++; $display("FAIL dc_valid[%0d] got=%b exp=%b", i, bus.valid_out, i % 8 == 6); end
      if (i % 8 == 6) begin
        checks++;
        if (bus.data_out !== OW'(dc[i/8])) begin failures++; $display("FAIL dc_data[%0d] got=%0d exp=%0d", i, $signed(bus.data_out), dc[i/8]); end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [OW-1:0] held;
    int n_acc;
    do_reset();
    set_coeffs(ramp);
    for (int i = 0; i < 4; i++) tick(1, IW'($urandom), 1, 0);
    held = bus.data_out;
    n_acc = 4;
    for (int i = 0; i < 5; i++) begin
      tick(1, IW'($urandom), 0, 0);
      checks++;
      if (obs_rdy !== 1'b0 || bus.valid_out !== 1'b1 || bus.data_out !== held) begin
        failures++;
        $display("FAIL bp_stall[%0d] ready=%b valid=%b data=%0d exp ready=0 valid=1 data=%0d", i, obs_rdy, bus.valid_out, $signed(bus.data_out), $signed(held));
      end
    end
    tick(1, IW'($urandom), 1, 0);
    checks++; if (obs_rdy !== 1'b1) begin failures++; $display("FAIL bp_release_ready got=%b exp=1", obs_rdy); end
    n_acc++;
    for (int i = 0; i < 11; i++) begin tick(1, IW'($urandom), 1, 0); n_acc++; end
    repeat (2) tick(0, '0, 1, 0);
    checks++;
    if (got_q.size() != n_acc / M || exp_q.size() != n_acc / M) begin
      failures++; $display("FAIL bp_count got=%0d exp=%0d", got_q.size(), n_acc / M);
    end else
      for (int i = 0; i < got_q.size(); i++) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL bp_data[%0d] got=%0d exp=%0d", i, $signed(got_q[i]), $signed(exp_q[i])); end
      end
  endtask

  task automatic test_bypass();
    logic [IW-1:0] tail[4];
    logic [OW-1:0] prev;
    do_reset();
    set_coeffs(ramp);
    for (int i = 1; i <= 8; i++) begin
      tick(1, IW'(i), 1, 1);
      if (i == 4 || i == 8) begin
        checks++;
        if (bus.valid_out !== 1'b1 || bus.data_out !== OW'(i * 32768)) begin
          failures++; $display("FAIL bypass_ramp[%0d] valid=%b got=%0d exp=%0d", i, bus.valid_out, $signed(bus.data_out), i * 32768);
        end
      end
    end
    tail = '{16'd0, 16'd0, 16'd0, 16'hFFFD};
    for (int i = 0; i < 4; i++) tick(1, tail[i], 1, 1);
    checks++;
    if (bus.data_out !== OW'(-98304)) begin failures++; $display("FAIL bypass_neg got=%0d exp=-98304", $signed(bus.data_out)); end
    prev = bus.data_out;
    // Toggle bypass off on a non-capture cycle: held output must not change.
    tick(1, IW'($urandom), 1, 0);
    checks++;
    if (bus.data_out !== prev) begin failures++; $display("FAIL bypass_hold got=%0d exp=%0d", $signed(bus.data_out), $signed(prev)); end
    tick(1, IW'($urandom), 1, 1);
    tick(1, IW'($urandom), 1, 1);
    tick(1, IW'($urandom), 1, 0);
    checks++;
    if (bus.data_out !== exp_q[$]) begin failures++; $display("FAIL bypass_toggle_filtered got=%0d exp=%0d", $signed(bus.data_out), $signed(exp_q[$])); end
    tick(1, IW'($urandom), 1, 0);
    tick(1, IW'($urandom), 1, 0);
    tick(1, IW'($urandom), 1, 0);
    tick(1, 16'd9, 1, 1);
    checks++;
    if (bus.data_out !== OW'(9 * 32768)) begin failures++; $display("FAIL bypass_toggle_on got=%0d exp=%0d", $signed(bus.data_out), 9 * 32768); end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    set_coeffs(ramp);
    for (int i = 0; i < 4; i++) tick(1, 16'd3, 1, 0);
    tick(0, '0, 0, 0);
    #2 arst_n = 1'b0;
    #1;
    checks++;
    if (bus.valid_out !== 1'b0 || bus.data_out !== '0 || bus.src_ready_out !== 1'b1) begin
      failures++; $display("FAIL midreset_async valid=%b data=%0d ready=%b exp 0/0/1", bus.valid_out, bus.data_out, bus.src_ready_out);
    end
    do_reset();
    tick(1, 16'd9, 1, 0);
    tick(1, 16'd9, 1, 0);
    do_reset();
    for (int i = 0; i < 4; i++) begin
      tick(1, 16'd5, 1, 0);
      checks++;
      if (bus.valid_out !== (i == 3)) begin failures++; $display("FAIL midreset_valid[%0d] got=%b exp=%b", i, bus.valid_out, i == 3); end
    end
    checks++;
    if (bus.data_out !== OW'(50)) begin failures++; $display("FAIL midreset_data got=%0d exp=50", $signed(bus.data_out)); end
  endtask

  task automatic test_random();
    int c[N];
    logic [IW-1:0] d;
    for (int round = 0; round < 2; round++) begin
      do_reset();
      for (int k = 0; k < N; k++) c[k] = (round == 0) ? int'($signed(CW'($urandom))) : -32768;
      set_coeffs(c);
      for (int i = 0; i < 300; i++) begin
        d = (round == 0) ? IW'($urandom) : (($urandom % 2) ? 16'h8000 : 16'h7FFF);
        tick($urandom % 4 != 0, d, $urandom % 3 != 0, $urandom % 5 == 0);
        checks++;
        if (obs_rdy !== m_rdy) begin failures++; $display("FAIL rand_ready[%0d.%0d] got=%b exp=%b", round, i, obs_rdy, m_rdy); end
      end
      repeat (3) tick(0, '0, 1, 0);
      checks++;
      if (got_q.size() != exp_q.size()) begin
        failures++; $display("FAIL rand_count[%0d] got=%0d exp=%0d", round, got_q.size(), exp_q.size());
      end else
        for (int i = 0; i < got_q.size(); i++) begin
          checks++;
          if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL rand_data[%0d.%0d] got=%0d exp=%0d", round, i, $signed(got_q[i]), $signed(exp_q[i])); end
        end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  initial begin
    bus.valid_in = 1'b0; bus.data_in = '0; bus.dst_ready_in = 1'b1;
    test_reset();
    test_impulse();
    test_dc_gaps();
    test_backpressure();
    test_bypass();
    test_reset_midstream();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
